ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and game-key decoder.
// Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop), publishes each good
// byte on scan_code/scan_valid, and tracks held levels for left/right/up/space using the
// E0 (extended) and F0 (break) prefixes.
// Optional macro PS2_ERR_KEY_CLEAR_EN: every frame_err pulse also clears all held keys.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]     scan_code_q, scan_code_d;
    logic           scan_valid_q, scan_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic [3:0]     key_q, key_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fall;

    // Two-flop synchronizers plus one delayed copy of the synced clock for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Frame FSM and decoder state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            key_q        <= 4'b0000;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            key_q        <= key_d;
        end
    end

    // Frame reception: advance on synced falling edges, abort silently on inter-edge timeout.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = '0;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q != StIdle && !fall) begin
            if (tmo_q == TmoLast) begin
                state_d   = StIdle;
                bit_cnt_d = 3'd0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d = {data_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = StParity;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                StParity: begin
                    parity_d = data_s2_q;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    if (data_s2_q && (^{shift_q, parity_q})) begin
                        scan_code_d  = shift_q;
                        scan_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Scan-code decode: prefix flags and held-key levels, one cycle after each good byte.
    always_comb begin
        logic       hit;
        logic [1:0] idx;
        ext_d = ext_q;
        brk_d = brk_q;
        key_d = key_q;
        hit   = 1'b0;
        idx   = 2'd0;

        if (scan_valid_q) begin
            if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q) begin
                    if (scan_code_q == 8'h6B) begin
                        hit = 1'b1;
                        idx = 2'd0;
                    end else if (scan_code_q == 8'h74) begin
                        hit = 1'b1;
                        idx = 2'd1;
                    end else if (scan_code_q == 8'h75) begin
                        hit = 1'b1;
                        idx = 2'd2;
                    end
                end else if (scan_code_q == 8'h29) begin
                    hit = 1'b1;
                    idx = 2'd3;
                end
                if (hit) begin
                    key_d[idx] = ~brk_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        // A corrupted frame may have been part of a prefixed sequence; drop the prefixes.
        if (frame_err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
`ifdef PS2_ERR_KEY_CLEAR_EN
            key_d = 4'b0000;
`else
            key_d = key_d;
`endif
        end
    end

    assign key        = key_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed sequences plus randomized frames compared
// against a byte-level model of the scan-code protocol.
module tb_ps2_key_decoder;

    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;
    int fe_cnt = 0;

    // Byte-level reference state.
    logic [3:0] m_key  = 4'b0000;
    logic [7:0] m_code = 8'h00;
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && scan_valid) sv_cnt++;
        if (!rst && frame_err) fe_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Game-key lookup: returns bit index or -1 when the byte maps to nothing.
    function automatic int key_index(input bit ext, input logic [7:0] b);
        if (ext) begin
            if (b == 8'h6B) return 0;
            if (b == 8'h74) return 1;
            if (b == 8'h75) return 2;
            return -1;
        end
        return (b == 8'h29) ? 3 : -1;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad);
        int idx;
        if (bad) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
`ifdef PS2_ERR_KEY_CLEAR_EN
            m_key = 4'b0000;
`endif
        end else begin
            m_code = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                idx = key_index(m_ext, b);
                if (idx >= 0) m_key[idx[1:0]] = ~m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_key  = 4'b0000;
        m_code = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Full frame with cycle-exact checks around the stop edge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        logic [3:0]  old_key;
        bit          bad;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        bad  = bad_par | bad_stop;
        for (int i = 0; i < 10; i++) drive_bit(bits[i]);
        ps2_data = bits[10];
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        old_key = m_key;
        model_frame(b, bad);
        // Two synchronizer stages, then the registered pulse.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scan_valid", 32'(scan_valid), 32'(!bad));
        check("frame_err", 32'(frame_err), 32'(bad));
        check("scan_code", 32'(scan_code), 32'(m_code));
        check("key_pre", 32'(key), 32'(bad ? m_key : old_key));
        @(negedge clk);
        check("pulse_width", 32'({scan_valid, frame_err}), 32'd0);
        check("key", 32'(key), 32'(m_key));
        repeat (HALF - 2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_partial(input int nbits);
        drive_bit(1'b0);
        for (int i = 1; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    initial begin
        logic [7:0] codes [8];
        int sv0, fe0;
        codes = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h29, 8'hE1, 8'h00};

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({key, scan_code, scan_valid, frame_err}), 32'd0);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Extended left make, then break; then space and up held together.
        sv0 = sv_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        check("e0_6b_key", 32'(key), 32'h1);
        check("e0_6b_pulses", 32'(sv_cnt - sv0), 32'd2);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        check("break_left", 32'(key), 32'h0);
        send_frame(8'h29, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("space_up", 32'(key), 32'hC);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        check("all_keys", 32'(key), 32'hF);

        // Parity error on space.
        fe0 = fe_cnt;
        send_frame(8'h29, 1'b1, 1'b0);
        check("parity_err_count", 32'(fe_cnt - fe0), 32'd1);
`ifdef PS2_ERR_KEY_CLEAR_EN
        check("parity_err_key", 32'(key), 32'h0);
`else
        check("parity_err_key", 32'(key), 32'hF);
`endif
        check("parity_err_code", 32'(scan_code), 32'h74);

        // Partial frame abandoned by timeout, then a clean space make.
        fe0 = fe_cnt;
        sv0 = sv_cnt;
        send_partial(5);
        repeat (TMO + 10) @(posedge clk);
        check("timeout_no_err", 32'(fe_cnt - fe0), 32'd0);
        check("timeout_no_valid", 32'(sv_cnt - sv0), 32'd0);
        send_frame(8'h29, 1'b0, 1'b0);
        check("timeout_space", 32'(key[3]), 32'd1);

        // Reset in the middle of a frame.
        send_partial(5);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("midreset_outputs", 32'({key, scan_code, scan_valid, frame_err}), 32'd0);
        repeat (HALF) @(posedge clk);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        check("midreset_right", 32'(key), 32'h2);

        // Randomized byte stream with occasional corrupted frames.
        for (int n = 0; n < 50; n++) begin
            logic [7:0] b;
            b = codes[$urandom_range(0, 7)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        check("final_key", 32'(key), 32'(m_key));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
